// File: rtl/udma_reg_if_nch.sv
// ---------------------------------------------------------------------------
// udma_reg_if_nch
// Generic uDMA peripheral register interface for N_CH channels.
//
// Each channel gets a SADDR/SIZE/CFG register set, and the in-band command
// path (UCA/UCS) can also set a channel's start address and size. The block
// also holds a soft-reset level, sticky status bits, and per-channel
// end-of-transfer events with an interrupt mask.
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   cfg_*_i / cfg_data_o     register bus (word addresses, combinational read)
//   cfg_ready_o              low only while a cfg write collides with a cmd hit
//   cfg_ch_*_o               per-channel config towards the channel logic
//   cfg_ch_*_i               per-channel state from the channel logic
//   cfg_do_rst_o             peripheral soft reset level
//   status_i                 sticky status set pulses
//   udma_cmd_*_i             in-band command stream (observed, not consumed)
//   irq_o                    masked end-of-transfer event interrupt
//
// Address map (word addresses)
//   4c+0 SADDR, 4c+1 SIZE, 4c+2 CFG, 4c+3 reserved   (channel c)
//   0x18 SETUP, 0x19 STATUS, 0x1A EVT_EN, 0x1B EVT
// ---------------------------------------------------------------------------
module udma_reg_if_nch #(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned N_CH           = 3,
  parameter int unsigned N_STATUS       = 2,
  parameter logic [3:0]  CMD_UCA        = 4'hD,
  parameter logic [3:0]  CMD_UCS        = 4'hE
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,

  input  logic [31:0]                        cfg_data_i,
  input  logic [4:0]                         cfg_addr_i,
  input  logic                               cfg_valid_i,
  input  logic                               cfg_rwn_i,
  output logic [31:0]                        cfg_data_o,
  output logic                               cfg_ready_o,

  output logic [N_CH*L2_AWIDTH_NOAL-1:0]     cfg_ch_startaddr_o,
  output logic [N_CH*TRANS_SIZE-1:0]         cfg_ch_size_o,
  output logic [N_CH-1:0]                    cfg_ch_continuous_o,
  output logic [N_CH-1:0]                    cfg_ch_en_o,
  output logic [N_CH-1:0]                    cfg_ch_clr_o,
  input  logic [N_CH-1:0]                    cfg_ch_en_i,
  input  logic [N_CH-1:0]                    cfg_ch_pending_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0]     cfg_ch_curr_addr_i,
  input  logic [N_CH*TRANS_SIZE-1:0]         cfg_ch_bytes_left_i,

  output logic                               cfg_do_rst_o,
  input  logic [N_STATUS-1:0]                status_i,

  input  logic [31:0]                        udma_cmd_i,
  input  logic                               udma_cmd_valid_i,
  input  logic                               udma_cmd_ready_i,

  output logic                               irq_o
);

  localparam int unsigned AW = L2_AWIDTH_NOAL;
  localparam int unsigned TW = TRANS_SIZE;

  localparam logic [4:0] ADDR_SETUP  = 5'h18;
  localparam logic [4:0] ADDR_STATUS = 5'h19;
  localparam logic [4:0] ADDR_EVT_EN = 5'h1A;
  localparam logic [4:0] ADDR_EVT    = 5'h1B;

  localparam logic [1:0] REG_SADDR = 2'd0;
  localparam logic [1:0] REG_SIZE  = 2'd1;
  localparam logic [1:0] REG_CFG   = 2'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [AW-1:0]       saddr_q [N_CH];
  logic [AW-1:0]       saddr_d [N_CH];
  logic [TW-1:0]       size_q  [N_CH];
  logic [TW-1:0]       size_d  [N_CH];
  logic [N_CH-1:0]     cont_q, cont_d;
  logic [N_CH-1:0]     en_pulse_q, en_pulse_d;
  logic [N_CH-1:0]     clr_pulse_q, clr_pulse_d;
  logic [N_CH-1:0]     evt_q, evt_d;
  logic [N_CH-1:0]     evt_en_q, evt_en_d;
  logic [N_CH-1:0]     ch_en_s_q, ch_en_dly_q;
  logic                do_rst_q, do_rst_d;
  logic [N_STATUS-1:0] sticky_q, sticky_d;
  logic                irq_q, irq_d;

  // -------------------------------------------------------------------------
  // Command decode
  // -------------------------------------------------------------------------
  logic [3:0] cmd_op;
  logic [2:0] cmd_idx;
  logic       cmd_fire;
  logic       cmd_is_uca;
  logic       cmd_is_ucs;
  logic       cmd_idx_ok;
  logic       cmd_hit;

  assign cmd_op     = udma_cmd_i[31:28];
  assign cmd_idx    = udma_cmd_i[26:24];
  assign cmd_fire   = udma_cmd_valid_i & udma_cmd_ready_i;
  assign cmd_is_uca = (cmd_op == CMD_UCA);
  assign cmd_is_ucs = (cmd_op == CMD_UCS);
  assign cmd_idx_ok = ({29'd0, cmd_idx} < N_CH);
  assign cmd_hit    = cmd_fire & cmd_idx_ok & (cmd_is_uca | cmd_is_ucs);

  // -------------------------------------------------------------------------
  // Bus handshake. A write that coincides with a cmd hit is stalled rather
  // than merged, so the two update sources never touch a register together.
  // -------------------------------------------------------------------------
  logic cfg_wr_req;
  logic cfg_we;
  logic status_rd;

  assign cfg_wr_req  = cfg_valid_i & ~cfg_rwn_i;
  assign cfg_ready_o = ~(cmd_hit & cfg_wr_req);
  assign cfg_we      = cfg_wr_req & cfg_ready_o;
  assign status_rd   = cfg_valid_i & cfg_rwn_i & (cfg_addr_i == ADDR_STATUS);

  // Two-flop history of the channel-active flags; a 1->0 between them is an
  // end-of-transfer event.
  logic [N_CH-1:0] evt_fall;
  assign evt_fall = ch_en_dly_q & ~ch_en_s_q;

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  logic [N_CH-1:0] evt_clr;

  always_comb begin
    saddr_d     = saddr_q;
    size_d      = size_q;
    cont_d      = cont_q;
    en_pulse_d  = '0;
    clr_pulse_d = '0;
    do_rst_d    = do_rst_q;
    evt_en_d    = evt_en_q;
    evt_clr     = '0;

    for (int c = 0; c < N_CH; c++) begin
      if (cfg_we && (cfg_addr_i[4:2] == 3'(c))) begin
        case (cfg_addr_i[1:0])
          REG_SADDR: saddr_d[c] = cfg_data_i[AW-1:0];
          REG_SIZE:  size_d[c]  = cfg_data_i[TW-1:0];
          REG_CFG: begin
            cont_d[c]      = cfg_data_i[0];
            en_pulse_d[c]  = cfg_data_i[4];
            clr_pulse_d[c] = cfg_data_i[5];
          end
          default: ;
        endcase
      end

      if (cmd_hit && (cmd_idx == 3'(c))) begin
        if (cmd_is_uca) begin
          saddr_d[c] = udma_cmd_i[AW-1:0];
        end
        if (cmd_is_ucs) begin
          size_d[c]     = udma_cmd_i[TW-1:0];
          en_pulse_d[c] = 1'b1;
        end
      end
    end

    if (cfg_we) begin
      case (cfg_addr_i)
        ADDR_SETUP:  do_rst_d = cfg_data_i[0];
        ADDR_EVT_EN: evt_en_d = cfg_data_i[N_CH-1:0];
        ADDR_EVT:    evt_clr  = cfg_data_i[N_CH-1:0];
        default: ;
      endcase
    end

    // Sets are OR-ed in after the clear so a same-cycle set is never lost.
    sticky_d = (status_rd ? '0 : sticky_q) | status_i;
    evt_d    = (evt_q & ~evt_clr) | evt_fall;
    irq_d    = |(evt_d & evt_en_d);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < N_CH; c++) begin
        saddr_q[c] <= '0;
        size_q[c]  <= '0;
      end
      cont_q      <= '0;
      en_pulse_q  <= '0;
      clr_pulse_q <= '0;
      evt_q       <= '0;
      evt_en_q    <= '0;
      ch_en_s_q   <= '0;
      ch_en_dly_q <= '0;
      do_rst_q    <= 1'b0;
      sticky_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      saddr_q     <= saddr_d;
      size_q      <= size_d;
      cont_q      <= cont_d;
      en_pulse_q  <= en_pulse_d;
      clr_pulse_q <= clr_pulse_d;
      evt_q       <= evt_d;
      evt_en_q    <= evt_en_d;
      ch_en_s_q   <= cfg_ch_en_i;
      ch_en_dly_q <= ch_en_s_q;
      do_rst_q    <= do_rst_d;
      sticky_q    <= sticky_d;
      irq_q       <= irq_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  always_comb begin
    cfg_data_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (cfg_addr_i[4:2] == 3'(c)) begin
        case (cfg_addr_i[1:0])
          REG_SADDR: cfg_data_o = 32'(cfg_ch_curr_addr_i[c*AW +: AW]);
          REG_SIZE:  cfg_data_o = 32'(cfg_ch_bytes_left_i[c*TW +: TW]);
          REG_CFG:   cfg_data_o = {26'h0, cfg_ch_pending_i[c], cfg_ch_en_i[c],
                                   3'b000, cont_q[c]};
          default:   cfg_data_o = '0;
        endcase
      end
    end
    case (cfg_addr_i)
      ADDR_SETUP:  cfg_data_o = {31'h0, do_rst_q};
      ADDR_STATUS: cfg_data_o = 32'(sticky_q);
      ADDR_EVT_EN: cfg_data_o = 32'(evt_en_q);
      ADDR_EVT:    cfg_data_o = 32'(evt_q);
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < N_CH; g++) begin : g_ch_out
    assign cfg_ch_startaddr_o[g*AW +: AW] = saddr_q[g];
    assign cfg_ch_size_o[g*TW +: TW]      = size_q[g];
  end

  assign cfg_ch_continuous_o = cont_q;
  assign cfg_ch_en_o         = en_pulse_q;
  assign cfg_ch_clr_o        = clr_pulse_q;
  assign cfg_do_rst_o        = do_rst_q;
  assign irq_o               = irq_q;

  // Upper data bits and cmd bit 27 carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{cfg_data_i, udma_cmd_i};

endmodule

// File: tb/tb_udma_reg_if_nch.sv
module tb_udma_reg_if_nch;

  localparam int AW = 12;
  localparam int TW = 16;
  localparam int NC = 3;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic [31:0]       cfg_data_i = '0;
  logic [4:0]        cfg_addr_i = '0;
  logic              cfg_valid_i = 1'b0;
  logic              cfg_rwn_i = 1'b1;
  logic [31:0]       cfg_data_o;
  logic              cfg_ready_o;
  logic [NC*AW-1:0]  cfg_ch_startaddr_o;
  logic [NC*TW-1:0]  cfg_ch_size_o;
  logic [NC-1:0]     cfg_ch_continuous_o;
  logic [NC-1:0]     cfg_ch_en_o;
  logic [NC-1:0]     cfg_ch_clr_o;
  logic [NC-1:0]     cfg_ch_en_i = 3'b010;
  logic [NC-1:0]     cfg_ch_pending_i = 3'b100;
  logic [NC*AW-1:0]  cfg_ch_curr_addr_i = {12'hABC, 12'h456, 12'h123};
  logic [NC*TW-1:0]  cfg_ch_bytes_left_i = {16'h3333, 16'h2222, 16'h1111};
  logic              cfg_do_rst_o;
  logic [1:0]        status_i = '0;
  logic [31:0]       udma_cmd_i = '0;
  logic              udma_cmd_valid_i = 1'b0;
  logic              udma_cmd_ready_i = 1'b0;
  logic              irq_o;

  udma_reg_if_nch dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .cfg_data_i          (cfg_data_i),
    .cfg_addr_i          (cfg_addr_i),
    .cfg_valid_i         (cfg_valid_i),
    .cfg_rwn_i           (cfg_rwn_i),
    .cfg_data_o          (cfg_data_o),
    .cfg_ready_o         (cfg_ready_o),
    .cfg_ch_startaddr_o  (cfg_ch_startaddr_o),
    .cfg_ch_size_o       (cfg_ch_size_o),
    .cfg_ch_continuous_o (cfg_ch_continuous_o),
    .cfg_ch_en_o         (cfg_ch_en_o),
    .cfg_ch_clr_o        (cfg_ch_clr_o),
    .cfg_ch_en_i         (cfg_ch_en_i),
    .cfg_ch_pending_i    (cfg_ch_pending_i),
    .cfg_ch_curr_addr_i  (cfg_ch_curr_addr_i),
    .cfg_ch_bytes_left_i (cfg_ch_bytes_left_i),
    .cfg_do_rst_o        (cfg_do_rst_o),
    .status_i            (status_i),
    .udma_cmd_i          (udma_cmd_i),
    .udma_cmd_valid_i    (udma_cmd_valid_i),
    .udma_cmd_ready_i    (udma_cmd_ready_i),
    .irq_o               (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rwn;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk_i);
    cfg_valid_i = 1'b1;
    cfg_rwn_i   = 1'b0;
    cfg_addr_i  = a;
    cfg_data_i  = d;
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
    cfg_rwn_i   = 1'b1;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk_i);
    cfg_valid_i = 1'b1;
    cfg_rwn_i   = 1'b1;
    cfg_addr_i  = a;
    #1;
    d = cfg_data_o;
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic cmd_pulse(input logic [31:0] c);
    @(negedge clk_i);
    udma_cmd_i       = c;
    udma_cmd_valid_i = 1'b1;
    udma_cmd_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    udma_cmd_valid_i = 1'b0;
    udma_cmd_ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;

    // reset state
    chk("rst_ready", 64'(cfg_ready_o), 64'h1);
    chk("rst_saddr", 64'(cfg_ch_startaddr_o), 64'h0);
    chk("rst_size", 64'(cfg_ch_size_o), 64'h0);
    chk("rst_cont", 64'(cfg_ch_continuous_o), 64'h0);
    chk("rst_en", 64'(cfg_ch_en_o), 64'h0);
    chk("rst_clr", 64'(cfg_ch_clr_o), 64'h0);
    chk("rst_do_rst", 64'(cfg_do_rst_o), 64'h0);
    chk("rst_irq", 64'(irq_o), 64'h0);

    // register map vectors
    vecs.push_back('{1'b1, 5'h00, 32'h0, 32'h0000_0123});
    vecs.push_back('{1'b1, 5'h05, 32'h0, 32'h0000_2222});
    vecs.push_back('{1'b1, 5'h08, 32'h0, 32'h0000_0ABC});
    vecs.push_back('{1'b1, 5'h03, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h0C, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h0E, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h1C, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h1F, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 5'h02, 32'h1, 32'h0});
    vecs.push_back('{1'b1, 5'h02, 32'h0, 32'h0000_0001});
    vecs.push_back('{1'b0, 5'h0A, 32'h1, 32'h0});
    vecs.push_back('{1'b1, 5'h0A, 32'h0, 32'h0000_0021});
    vecs.push_back('{1'b1, 5'h06, 32'h0, 32'h0000_0010});
    vecs.push_back('{1'b0, 5'h18, 32'h1, 32'h0});
    vecs.push_back('{1'b1, 5'h18, 32'h0, 32'h0000_0001});
    vecs.push_back('{1'b0, 5'h1A, 32'hFF, 32'h0});
    vecs.push_back('{1'b1, 5'h1A, 32'h0, 32'h0000_0007});
    vecs.push_back('{1'b1, 5'h19, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h1B, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 5'h00, 32'hFFFF_F5A5, 32'h0});
    vecs.push_back('{1'b0, 5'h01, 32'hABCD_1234, 32'h0});
    vecs.push_back('{1'b0, 5'h04, 32'h0000_0777, 32'h0});
    vecs.push_back('{1'b0, 5'h1A, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 5'h1A, 32'h0, 32'h0});

    foreach (vecs[i]) begin
      if (vecs[i].rwn) begin
        cfg_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d_rd_%0h", i, vecs[i].addr), 64'(rd), 64'(vecs[i].exp));
      end else begin
        cfg_write(vecs[i].addr, vecs[i].data);
      end
    end

    chk("tbl_saddr", 64'(cfg_ch_startaddr_o), 64'h000_777_5A5);
    chk("tbl_size0", 64'(cfg_ch_size_o[0 +: TW]), 64'h1234);
    chk("tbl_cont", 64'(cfg_ch_continuous_o), 64'h5);
    chk("tbl_do_rst", 64'(cfg_do_rst_o), 64'h1);

    // CH1 CFG = 0x11: one-cycle en pulse, continuous set
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h06; cfg_data_i = 32'h11;
    #1;
    chk("ch1_en_before", 64'(cfg_ch_en_o), 64'h0);
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
    chk("ch1_en_pulse", 64'(cfg_ch_en_o), 64'h2);
    chk("ch1_cont", 64'(cfg_ch_continuous_o), 64'h7);
    @(posedge clk_i); #1;
    chk("ch1_en_end", 64'(cfg_ch_en_o), 64'h0);
    cfg_read(5'h06, rd);
    chk("ch1_cfg_rd", 64'(rd), 64'h11);

    // back-to-back CH0 CFG writes: clr, then clr+en
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h02; cfg_data_i = 32'h20;
    @(posedge clk_i); #1;
    chk("b2b1_clr", 64'(cfg_ch_clr_o), 64'h1);
    chk("b2b1_en", 64'(cfg_ch_en_o), 64'h0);
    @(negedge clk_i);
    cfg_data_i = 32'h30;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
    chk("b2b2_clr", 64'(cfg_ch_clr_o), 64'h1);
    chk("b2b2_en", 64'(cfg_ch_en_o), 64'h1);
    @(posedge clk_i); #1;
    chk("b2b3_pulses", 64'({cfg_ch_clr_o, cfg_ch_en_o}), 64'h0);
    chk("b2b_cont", 64'(cfg_ch_continuous_o), 64'h6);

    // UCS commands
    cmd_pulse(32'hE100_0040);
    chk("ucs_size1", 64'(cfg_ch_size_o[TW +: TW]), 64'h40);
    chk("ucs_en", 64'(cfg_ch_en_o), 64'h2);
    @(posedge clk_i); #1;
    chk("ucs_en_end", 64'(cfg_ch_en_o), 64'h0);
    cmd_pulse(32'hE700_0099);
    chk("ucs_idx7_size", 64'(cfg_ch_size_o), 64'h0000_0040_1234);
    chk("ucs_idx7_en", 64'(cfg_ch_en_o), 64'h0);

    // UCA colliding with a SADDR write
    @(negedge clk_i);
    udma_cmd_i = 32'hD000_0333; udma_cmd_valid_i = 1'b1; udma_cmd_ready_i = 1'b1;
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h00; cfg_data_i = 32'h321;
    #1;
    chk("coll_ready", 64'(cfg_ready_o), 64'h0);
    @(posedge clk_i); #1;
    chk("coll_uca", 64'(cfg_ch_startaddr_o[0 +: AW]), 64'h333);
    udma_cmd_valid_i = 1'b0; udma_cmd_ready_i = 1'b0;
    #1;
    chk("coll_ready_after", 64'(cfg_ready_o), 64'h1);
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
    chk("coll_held_wr", 64'(cfg_ch_startaddr_o[0 +: AW]), 64'h321);

    // reads are never stalled by a cmd hit
    @(negedge clk_i);
    udma_cmd_i = 32'hD200_0AAA; udma_cmd_valid_i = 1'b1; udma_cmd_ready_i = 1'b1;
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = 5'h00;
    #1;
    chk("rd_cmd_ready", 64'(cfg_ready_o), 64'h1);
    chk("rd_cmd_data", 64'(cfg_data_o), 64'h123);
    @(posedge clk_i); #1;
    udma_cmd_valid_i = 1'b0; udma_cmd_ready_i = 1'b0; cfg_valid_i = 1'b0;
    chk("uca_ch2", 64'(cfg_ch_startaddr_o[2*AW +: AW]), 64'hAAA);

    // non-hit commands do not stall writes
    @(negedge clk_i);
    udma_cmd_i = 32'hE700_0000; udma_cmd_valid_i = 1'b1; udma_cmd_ready_i = 1'b1;
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h18; cfg_data_i = 32'h1;
    #1;
    chk("idx7_ready", 64'(cfg_ready_o), 64'h1);
    udma_cmd_i = 32'hE100_0055; udma_cmd_ready_i = 1'b0;
    #1;
    chk("notready_ready", 64'(cfg_ready_o), 64'h1);
    @(posedge clk_i); #1;
    udma_cmd_valid_i = 1'b0; cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
    chk("notready_size1", 64'(cfg_ch_size_o[TW +: TW]), 64'h40);

    // sticky status: set during read survives
    @(negedge clk_i);
    status_i = 2'b01;
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = 5'h19;
    #1;
    chk("sticky_rd_old", 64'(cfg_data_o), 64'h0);
    @(posedge clk_i); #1;
    status_i = 2'b00; cfg_valid_i = 1'b0;
    cfg_read(5'h19, rd);
    chk("sticky_rd_set", 64'(rd), 64'h1);
    cfg_read(5'h19, rd);
    chk("sticky_rd_clr", 64'(rd), 64'h0);
    @(negedge clk_i);
    status_i = 2'b10;
    @(posedge clk_i); #1;
    status_i = 2'b00;
    cfg_read(5'h19, rd);
    chk("sticky_b1", 64'(rd), 64'h2);
    cfg_read(5'h19, rd);
    chk("sticky_b1_clr", 64'(rd), 64'h0);

    // events and interrupt
    cfg_write(5'h1A, 32'h4);
    @(negedge clk_i);
    cfg_ch_en_i = 3'b110;
    repeat (3) @(posedge clk_i);
    #1;
    chk("evt_rise_irq", 64'(irq_o), 64'h0);
    @(negedge clk_i);
    cfg_ch_en_i = 3'b010;
    @(posedge clk_i); #1;
    chk("evt_irq_k", 64'(irq_o), 64'h0);
    @(posedge clk_i); #1;
    chk("evt_irq_k1", 64'(irq_o), 64'h1);
    cfg_read(5'h1B, rd);
    chk("evt_rd", 64'(rd), 64'h4);
    cfg_write(5'h1B, 32'h4);
    chk("evt_w1c_irq", 64'(irq_o), 64'h0);
    cfg_read(5'h1B, rd);
    chk("evt_w1c_rd", 64'(rd), 64'h0);

    @(negedge clk_i);
    cfg_ch_en_i = 3'b000;
    repeat (3) @(posedge clk_i);
    #1;
    chk("evt_masked_irq", 64'(irq_o), 64'h0);
    cfg_read(5'h1B, rd);
    chk("evt_masked_rd", 64'(rd), 64'h2);
    cfg_write(5'h1B, 32'h2);

    // set wins over same-cycle clear
    @(negedge clk_i);
    cfg_ch_en_i = 3'b100;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    cfg_ch_en_i = 3'b000;
    @(posedge clk_i);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h1B; cfg_data_i = 32'h4;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1;
    chk("evt_setwins_irq", 64'(irq_o), 64'h1);
    cfg_read(5'h1B, rd);
    chk("evt_setwins_rd", 64'(rd), 64'h4);
    cfg_write(5'h1B, 32'h4);
    chk("evt_final_irq", 64'(irq_o), 64'h0);

    // unmapped channel write has no effect
    cfg_write(5'h0C, 32'hFFFF_FFFF);
    @(posedge clk_i); #1;
    chk("unmap_saddr", 64'(cfg_ch_startaddr_o), 64'hAAA_777_321);
    chk("unmap_size", 64'(cfg_ch_size_o), 64'h0000_0040_1234);
    chk("unmap_misc", 64'({cfg_ch_continuous_o, cfg_ch_en_o, cfg_ch_clr_o, cfg_do_rst_o, irq_o}),
        64'b110_000_000_1_0);
    cfg_read(5'h0C, rd);
    chk("unmap_rd", 64'(rd), 64'h0);

    // reset in the middle of a pulse
    cfg_write(5'h02, 32'h10);
    chk("midrst_pulse", 64'(cfg_ch_en_o), 64'h1);
    rstn_i = 1'b0;
    #1;
    chk("midrst_en", 64'(cfg_ch_en_o), 64'h0);
    chk("midrst_saddr", 64'(cfg_ch_startaddr_o), 64'h0);
    chk("midrst_misc", 64'({cfg_ch_continuous_o, cfg_do_rst_o}), 64'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udma_reg_if_nch.md
# udma_reg_if_nch

Parametrised uDMA peripheral register interface for a configurable number of uDMA channels (N_CH). It replaces the fixed RX/TX/CMD register file with one generic per-channel register set and keeps the in-band command setup path (UCA/UCS). New compared with the fixed version:
- lossless sticky status;
- per-channel end-of-transfer events with interrupt mask;
- a cfg write back-pressured during command collisions instead of dropped.

It sits between the APB/cfg bus and the uDMA channel logic of a peripheral (I2C and successors).

## Interface
Parameters:
- L2_AWIDTH_NOAL, 12, L2 address width of channel start address
- TRANS_SIZE, 16, transfer size width
- N_CH, 3, number of uDMA channels, legal 1..6
- N_STATUS, 2, number of sticky status inputs, legal 1..32
- CMD_UCA, 4'hD, command opcode: set channel start address
- CMD_UCS, 4'hE, command opcode: set channel size and enable

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- cfg_data_i  in  32  write data
- cfg_addr_i  in  5  word address
- cfg_valid_i  in  1  request valid
- cfg_rwn_i  in  1  1 = read, 0 = write
- cfg_data_o  out  32  read data
- cfg_ready_o  out  1  request accepted
- cfg_ch_startaddr_o  out  N_CH*L2_AWIDTH_NOAL  start address; channel c in slice [c*W +: W]
- cfg_ch_size_o  out  N_CH*TRANS_SIZE  transfer size per channel
- cfg_ch_continuous_o  out  N_CH  continuous mode per channel
- cfg_ch_en_o  out  N_CH  one-cycle enable pulse per channel
- cfg_ch_clr_o  out  N_CH  one-cycle clear pulse per channel
- cfg_ch_en_i  in  N_CH  channel-active flag from the channel
- cfg_ch_pending_i  in  N_CH  channel pending flag
- cfg_ch_curr_addr_i  in  N_CH*L2_AWIDTH_NOAL  current address per channel
- cfg_ch_bytes_left_i  in  N_CH*TRANS_SIZE  bytes left per channel
- cfg_do_rst_o  out  1  peripheral soft reset level
- status_i  in  N_STATUS  status set pulses
- udma_cmd_i  in  32  command word
- udma_cmd_valid_i  in  1  command valid
- udma_cmd_ready_i  in  1  command ready
- irq_o  out  1  event interrupt

## Operation
Address map (word addresses):
- Channel c: 4c = SADDR, 4c+1 = SIZE, 4c+2 = CFG; 4c+3 is reserved.
- 0x18 SETUP, 0x19 STATUS, 0x1A EVT_EN, 0x1B EVT.
- Channels ≥ N_CH, reserved and unmapped addresses: read 0, writes ignored.

Writes:
- SADDR/SIZE store the low bits of the write data.
- CFG: bit 5 pulses clr, bit 4 pulses en, bit 0 stores continuous.
- SETUP bit 0 stores do_rst.
- EVT_EN[N_CH-1:0] stores the event mask.
- EVT is write-1-to-clear.

Reads are combinational:
- SADDR: curr_addr, zero-extended.
- SIZE: bytes_left, zero-extended.
- CFG: {26'h0, pending, en_i, 3'b0, continuous}.
- SETUP: {31'h0, do_rst}.
- STATUS: sticky bits, zero-extended.
- EVT_EN, EVT: mask and pending bits, zero-extended.

Command path (fires when udma_cmd_valid_i & udma_cmd_ready_i):
- Opcode is udma_cmd_i[31:28]; channel index is [26:24].
- UCA: startaddr[idx] ← cmd[L2_AWIDTH_NOAL-1:0].
- UCS: size[idx] ← cmd[TRANS_SIZE-1:0], and en[idx] pulses.
- An index ≥ N_CH or any other opcode is ignored.
- Call a command that is accepted, has a legal index and is UCA/UCS a "cmd hit".

Collision: cfg_ready_o = ~(cmd hit & cfg_valid_i & ~cfg_rwn_i).
- The stalled write is not applied and must be held by the master.
- Reads are always ready.

Sticky status:
- A bit is set by status_i and cleared by a STATUS read.
- A set in the same cycle as the read wins; no event is lost.

Events and interrupt:
- evt[c] is set on a falling edge of cfg_ch_en_i[c], detected with a registered copy.
- A set wins over a same-cycle W1C clear.
- irq_o = |(evt & evt_en), driven from registers.

## Timing
- Reset: all registers, startaddr/size/continuous, en/clr pulses, do_rst, sticky, evt, evt_en, en_i delay flops and irq_o are 0. cfg_ready_o is 1 when idle.
- A write accepted at edge k updates the register after edge k. The en/clr pulse is high for exactly cycle k+1.
- UCS accepted at edge k: en pulses during cycle k+1.
- Falling edge of cfg_ch_en_i seen at edge k: evt is set after edge k+1, and irq_o rises in the same cycle.
- Back-to-back writes to CFG give back-to-back pulses; each pulse is one cycle per accepted write.
- Reset asserted mid-operation clears everything immediately, including in-flight pulses.

## Test plan
- Write CH1 CFG = 0x11 → cfg_ch_en_o[1] is a 1-cycle pulse and continuous[1] = 1; a CH1 CFG read returns 0x01 | (en_i << 4) | (pending << 5).
- UCS command 0xE100_0040 (idx 1) → size[1] = 0x40 with an en[1] pulse; the same command with idx 7 → no change.
- UCA command in the same cycle as a write to CH0 SADDR → cfg_ready_o = 0 for that cycle; the write completes the next cycle with the value held.
- status_i[0] pulse in the same cycle as a STATUS read → read returns the old value and bit 0 remains 1; the next read returns 1 and clears it.
- EVT_EN = 0x4, then cfg_ch_en_i[2] goes 1→0 → EVT = 0x4 and irq_o = 1; writing EVT = 0x4 → irq_o = 0.
- Read address 0x0C with N_CH = 3 → 0; a write to it has no effect on any output.
